regfile_zflag: RTL and testbench
================================

Name: regfile_zflag

Overview:
- Operand and state stage directly upstream of the 8-bit ALU.
- Holds the CPU's 16×8 general register file; two combinational read ports drive ALU inputs a and b, and one synchronous write port accepts the write-back result.
- Also holds the architectural zero flag: captures the ALU zero output on flag-setting instructions and supports a one-deep save/restore for subroutine/interrupt entry and exit.

Parameters:
- NREG, 16, number of registers; address width is log2(NREG) = 4.
- BYPASS, 0, 1 makes same-cycle write data visible on the read ports; 0 returns the stored (old) value.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- ra1  input  4  read address, port 1 (feeds ALU a)
- ra2  input  4  read address, port 2 (feeds ALU b)
- rd1  output  8  read data, port 1
- rd2  output  8  read data, port 2
- we3  input  1  register write enable
- wa3  input  4  write address
- wd3  input  8  write data (ALU y or other write-back source)
- zero_in  input  1  ALU zero output
- we_zero  input  1  load zero_in into the flag this cycle
- save_flags  input  1  copy the flag into the shadow slot
- restore_flags  input  1  copy the shadow slot into the flag
- zero_flag  output  1  registered architectural zero flag

Behaviour:
- Reset, synchronous: at a clk edge with reset=1, all registers become 8'h00, zero_flag becomes 0, and the shadow flag becomes 0.
  - Reset overrides every other input that cycle.
  - Reset mid-sequence discards any pending write or save.
- Register 0 is hardwired to 8'h00.
  - Writes to wa3=0 are ignored.
  - Reads of address 0 always return 8'h00, including under BYPASS.
- Read ports are purely combinational: rd1 = R[ra1], rd2 = R[ra2], with zero cycles of latency.
- Write: on a clk edge with we3=1 and wa3≠0, R[wa3] ← wd3. The new value is visible on the read ports from the following cycle.
- Same-cycle read of the register being written (we3=1, wa3=raN≠0):
  - BYPASS=0: rdN shows the old value.
  - BYPASS=1: rdN shows wd3 combinationally.
- Both read ports may address the same register and both return the same value.
- Zero flag update, evaluated at each clk edge when reset=0:
  - restore_flags=1: zero_flag ← shadow. This has priority over we_zero; zero_in is ignored that cycle.
  - Else we_zero=1: zero_flag ← zero_in.
  - Else: zero_flag holds.
- Shadow update: when save_flags=1, shadow ← the current zero_flag, i.e. the value before this edge's update.
- save_flags=1 and restore_flags=1 in the same cycle swap the two values: zero_flag ← old shadow, shadow ← old zero_flag.
- save_flags=1 and we_zero=1 in the same cycle: the shadow receives the pre-update flag, and the flag receives zero_in.
- The shadow is one level deep; a second save overwrites it with no error indication.
- zero_flag is a register output (not combinational from zero_in) and is never X after reset.
- X/Z on an address with the matching enable asserted gives an undefined result; the bench must not drive this.

Test Plan:
- Reset, then read all addresses on both ports → rd1=rd2=8'h00 for ra=0..15; zero_flag=0.
- Write wd3=8'h5A to wa3=3, then 8'hC3 to wa3=15; next cycle read ra1=3, ra2=15 → rd1=8'h5A, rd2=8'hC3. Write 8'hFF to wa3=0 → reading address 0 still gives 8'h00.
- With BYPASS=0, set we3=1, wa3=7, wd3=8'h11 while ra1=7 and R7 previously 8'h22 → rd1=8'h22 in that cycle and 8'h11 the next. Repeat with BYPASS=1 → rd1=8'h11 in the same cycle.
- Flag path:
  - we_zero=1, zero_in=1 → zero_flag=1 after the edge.
  - we_zero=0, zero_in=0 → holds at 1.
  - save_flags=1 together with we_zero=1, zero_in=0 → zero_flag=0, shadow=1.
  - restore_flags=1 with we_zero=1, zero_in=0 → zero_flag=1.
- Swap: zero_flag=0, shadow=1; assert save_flags=restore_flags=1 → zero_flag=1, shadow=0. A following restore gives zero_flag=0.
- Write R5=8'h9C and set zero_flag=1, then assert reset with we3=1, wa3=5, wd3=8'hAA, we_zero=1, zero_in=1 → after the edge R5=8'h00, zero_flag=0, shadow=0.

Source files
------------

// File: rtl/regfile_zflag.sv
// Operand/state stage ahead of the 8-bit ALU: a 2R/1W register file with r0 tied
// to zero, plus the architectural zero flag and its one-deep save/restore slot.

module regfile_zflag_rdport #(
  parameter int NREG   = 16,
  parameter int BYPASS = 0,
  parameter int AW     = $clog2(NREG)
) (
  input  logic [NREG-1:0][7:0] regs_i,
  input  logic [AW-1:0]        ra_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        wa_i,
  input  logic [7:0]           wd_i,
  output logic [7:0]           rd_o
);
  always_comb begin
    rd_o = regs_i[ra_i];
    // r0 wins over the forward path so a write to address 0 can never leak out
    if (ra_i == '0)
      rd_o = '0;
    else if ((BYPASS != 0) && we_i && (wa_i == ra_i))
      rd_o = wd_i;
  end
endmodule

module regfile_zflag #(
  parameter int NREG   = 16,
  parameter int BYPASS = 0,
  parameter int AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [7:0]    rd1,
  output logic [7:0]    rd2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [7:0]    wd3,
  input  logic          zero_in,
  input  logic          we_zero,
  input  logic          save_flags,
  input  logic          restore_flags,
  output logic          zero_flag
);
  localparam int NRD = 2;

  logic [NREG-1:0][7:0] regs_q;
  logic                 zflag_q, zflag_d;
  logic                 shadow_q, shadow_d;

  logic [NRD-1:0][AW-1:0] ra;
  logic [NRD-1:0][7:0]    rd;

  assign ra  = {ra2, ra1};
  assign rd1 = rd[0];
  assign rd2 = rd[1];

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      regfile_zflag_rdport #(.NREG(NREG), .BYPASS(BYPASS), .AW(AW)) u_rd (
        .regs_i (regs_q),
        .ra_i   (ra[g]),
        .we_i   (we3),
        .wa_i   (wa3),
        .wd_i   (wd3),
        .rd_o   (rd[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      regs_q <= '0;
    else if (we3 && (wa3 != '0))
      regs_q[wa3] <= wd3;
  end

  // Restore outranks a flag load; save always captures the pre-edge flag,
  // which makes save+restore a swap.
  always_comb begin
    zflag_d  = zflag_q;
    shadow_d = shadow_q;
    if (restore_flags)
      zflag_d = shadow_q;
    else if (we_zero)
      zflag_d = zero_in;
    if (save_flags)
      shadow_d = zflag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zflag_q  <= 1'b0;
      shadow_q <= 1'b0;
    end else begin
      zflag_q  <= zflag_d;
      shadow_q <= shadow_d;
    end
  end

  assign zero_flag = zflag_q;
endmodule

// File: tb/tb_regfile_zflag.sv
// Directed plus random checks of regfile_zflag, BYPASS=0 and BYPASS=1 side by side,
// against an array/flag model of the architectural state.

module tb_regfile_zflag;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ra1, ra2, wa3;
  logic       we3, zero_in, we_zero, save_flags, restore_flags;
  logic [7:0] wd3;
  logic [7:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic       zf_0, zf_1;

  always #5 clk = ~clk;

  regfile_zflag #(.NREG(16), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
    .we3(we3), .wa3(wa3), .wd3(wd3), .zero_in(zero_in), .we_zero(we_zero),
    .save_flags(save_flags), .restore_flags(restore_flags), .zero_flag(zf_0));

  regfile_zflag #(.NREG(16), .BYPASS(1)) u_by (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
    .we3(we3), .wa3(wa3), .wd3(wd3), .zero_in(zero_in), .we_zero(we_zero),
    .save_flags(save_flags), .restore_flags(restore_flags), .zero_flag(zf_1));

  int total = 0;
  int bad   = 0;

  // architectural model
  logic [7:0] mreg [16];
  logic       mz, msh;

  // last observed values, for directed constant checks
  logic [7:0] o_rd1_nb, o_rd1_by, o_rd2_nb;
  logic       o_zf;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int byp, input logic [3:0] a,
                                        input logic we, input logic [3:0] wa,
                                        input logic [7:0] wd);
    if (a == 4'd0) return 8'h00;
    if (byp != 0 && we && wa == a) return wd;
    return mreg[a];
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] a1, input logic [3:0] a2,
                       input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic zi, input logic wz, input logic sv, input logic rs);
    logic nz;
    @(negedge clk);
    reset = rst; ra1 = a1; ra2 = a2; we3 = we; wa3 = wa; wd3 = wd;
    zero_in = zi; we_zero = wz; save_flags = sv; restore_flags = rs;
    #1;
    chk("rd1_nb", rd1_0, exp_rd(0, a1, we, wa, wd));
    chk("rd2_nb", rd2_0, exp_rd(0, a2, we, wa, wd));
    chk("rd1_by", rd1_1, exp_rd(1, a1, we, wa, wd));
    chk("rd2_by", rd2_1, exp_rd(1, a2, we, wa, wd));
    o_rd1_nb = rd1_0; o_rd2_nb = rd2_0; o_rd1_by = rd1_1;
    @(posedge clk);
    if (rst) begin
      foreach (mreg[i]) mreg[i] = 8'h00;
      mz = 1'b0; msh = 1'b0;
    end else begin
      if (we && wa != 4'd0) mreg[wa] = wd;
      nz = rs ? msh : (wz ? zi : mz);
      if (sv) msh = mz;
      mz = nz;
    end
    #1;
    chk("zf_nb", {7'b0, zf_0}, {7'b0, mz});
    chk("zf_by", {7'b0, zf_1}, {7'b0, mz});
    o_zf = zf_0;
  endtask

  task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
    cycle(1'b0, a1, a2, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flag(input logic zi, input logic wz, input logic sv, input logic rs);
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, zi, wz, sv, rs);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [7:0] wd, input logic [3:0] a1);
    cycle(1'b0, a1, 4'd0, 1'b1, wa, wd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ra1 = '0; ra2 = '0; we3 = 1'b0; wa3 = '0; wd3 = '0;
    zero_in = 1'b0; we_zero = 1'b0; save_flags = 1'b0; restore_flags = 1'b0;
    @(posedge clk); #1;
    foreach (mreg[i]) mreg[i] = 8'h00;
    mz = 1'b0; msh = 1'b0;
    chk("reset_zf", {7'b0, zf_0}, 8'h00);

    // reset state on every address, both ports
    for (int a = 0; a < 16; a++) begin
      idle(4'(a), 4'(15 - a));
      chk("reset_rd1", o_rd1_nb, 8'h00);
      chk("reset_rd2", o_rd2_nb, 8'h00);
    end

    // basic write/read and r0 hardwiring
    wr(4'd3, 8'h5A, 4'd0);
    wr(4'd15, 8'hC3, 4'd0);
    idle(4'd3, 4'd15);
    chk("w3", o_rd1_nb, 8'h5A);
    chk("w15", o_rd2_nb, 8'hC3);
    wr(4'd0, 8'hFF, 4'd0);
    chk("r0_bypass", o_rd1_by, 8'h00);
    idle(4'd0, 4'd0);
    chk("r0", o_rd1_nb, 8'h00);
    idle(4'd3, 4'd3);
    chk("same_reg", o_rd2_nb, 8'h5A);

    // same-cycle read of the register being written
    wr(4'd7, 8'h22, 4'd0);
    wr(4'd7, 8'h11, 4'd7);
    chk("old_nb", o_rd1_nb, 8'h22);
    chk("new_by", o_rd1_by, 8'h11);
    idle(4'd7, 4'd0);
    chk("after_nb", o_rd1_nb, 8'h11);

    // flag path
    flag(1'b1, 1'b1, 1'b0, 1'b0); chk("zload", {7'b0, o_zf}, 8'h01);
    flag(1'b0, 1'b0, 1'b0, 1'b0); chk("zhold", {7'b0, o_zf}, 8'h01);
    flag(1'b0, 1'b1, 1'b1, 1'b0); chk("save_load", {7'b0, o_zf}, 8'h00);
    flag(1'b0, 1'b1, 1'b0, 1'b1); chk("restore_pri", {7'b0, o_zf}, 8'h01);
    flag(1'b0, 1'b1, 1'b0, 1'b0); chk("zclr", {7'b0, o_zf}, 8'h00);
    flag(1'b0, 1'b0, 1'b1, 1'b1); chk("swap", {7'b0, o_zf}, 8'h01);
    flag(1'b0, 1'b0, 1'b0, 1'b1); chk("swap_rest", {7'b0, o_zf}, 8'h00);

    // reset beats a pending write, flag load and saved shadow
    wr(4'd5, 8'h9C, 4'd0);
    flag(1'b1, 1'b1, 1'b0, 1'b0);
    flag(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd5, 4'd0, 1'b1, 4'd5, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_zf", {7'b0, o_zf}, 8'h00);
    idle(4'd5, 4'd0);
    chk("rst_r5", o_rd1_nb, 8'h00);
    flag(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_shadow", {7'b0, o_zf}, 8'h00);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0),
            4'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
